uart_boot_responder: RTL

UART-side command responder for the bootloader path. Deserialises 8N1 bytes from the host's serial command sender on `RX`, parses write/read/done frames, drives a simple single-cycle memory port to load instruction memory, and returns acknowledge or read-data bytes on `TX` at the same baud. It is the target-side counterpart of the host command interface and sits between the board GPIO UART pins and the instruction-memory write port.

---
 rtl/uart_boot_responder_if.sv | 10 +
 rtl/uart_boot_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_boot_responder_if.sv
// uart_boot_responder_if: single-cycle memory port between the boot responder and instruction memory
interface uart_boot_responder_if;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport master(output mem_we, mem_re, mem_addr, mem_wdata, input mem_rdata);
  modport slave(input mem_we, mem_re, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/uart_boot_responder.sv
// uart_boot_responder: 8N1 UART command parser that loads instruction memory and answers on TX
module uart_boot_responder #(
  parameter logic [12:0] BAUD_DIV = 13'h01b2,
  parameter logic [7:0]  ACK      = 8'hA5,
  parameter logic [7:0]  NAK      = 8'hEE
) (
  input  logic clk,
  input  logic rst,
  input  logic RX,
  output logic TX,
  uart_boot_responder_if.master mem,
  output logic boot_done,
  output logic busy
);
  localparam logic [12:0] HALF = BAUD_DIV >> 1;
  typedef enum logic [2:0] {CMD, ADDR, DATA, EXEC, RD_WAIT, RESP} state_t;
  state_t state, state_n;
  logic rx_s1, rx_s2, rx_prev;
  logic rx_on, rx_half, rx_valid, rx_ferr;
  logic [3:0] rx_bit;
  logic [12:0] rx_cnt;
  logic [7:0] rx_byte;
  logic tx_start, tx_run, tx_done, tx_ready;
  logic [7:0] tx_data, tx_sh;
  logic [3:0] tx_bit;
  logic [12:0] tx_cnt;
  logic [1:0] cnt;
  logic is_rd;
  logic [15:0] addr_buf;
  logic [23:0] data_buf;
  logic [31:0] resp_buf;
  logic [2:0] resp_cnt;

  // rx_cnt counts cycles since the last sample point; the first interval is half a bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      rx_on <= 1'b0;
      rx_half <= 1'b0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      rx_bit <= '0;
      rx_cnt <= '0;
      rx_byte <= '0;
    end else begin
      {rx_s1, rx_s2, rx_prev} <= {RX, rx_s1, rx_s2};
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      if (!rx_on) begin
        if (rx_prev && !rx_s2) begin
          rx_on <= 1'b1;
          rx_half <= 1'b1;
          rx_cnt <= 13'd1;
          rx_bit <= 4'd0;
        end
      end else if (rx_cnt == (rx_half ? HALF : BAUD_DIV)) begin
        rx_cnt <= 13'd1;
        if (rx_half) begin
          rx_half <= 1'b0;
          rx_on <= ~rx_s2;
        end else if (rx_bit == 4'd8) begin
          rx_on <= 1'b0;
          rx_valid <= rx_s2;
          rx_ferr <= ~rx_s2;
        end else begin
          rx_byte <= {rx_s2, rx_byte[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else
        rx_cnt <= rx_cnt + 13'd1;
    end

  // A new byte may start in the last stop cycle so queued bytes leave exactly 10 bits apart
  assign tx_done  = tx_run && tx_bit == 4'd9 && tx_cnt == BAUD_DIV;
  assign tx_ready = !tx_run || tx_done;
  assign tx_data  = resp_buf[31:24];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      TX <= 1'b1;
      tx_run <= 1'b0;
      tx_sh <= '0;
      tx_bit <= '0;
      tx_cnt <= '0;
    end else if (tx_start && tx_ready) begin
      TX <= 1'b0;
      tx_run <= 1'b1;
      tx_sh <= tx_data;
      tx_bit <= 4'd0;
      tx_cnt <= 13'd1;
    end else if (tx_run) begin
      if (tx_cnt == BAUD_DIV) begin
        tx_cnt <= 13'd1;
        if (tx_bit == 4'd9)
          tx_run <= 1'b0;
        else begin
          TX <= tx_sh[0];
          tx_sh <= {1'b1, tx_sh[7:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else
        tx_cnt <= tx_cnt + 13'd1;
    end

  always_comb begin
    state_n = state;
    tx_start = 1'b0;
    case (state)
      CMD:     if (rx_valid) state_n = (rx_byte == 8'h01 || rx_byte == 8'h02) ? ADDR : RESP;
      ADDR:    if (rx_valid && cnt[0]) state_n = is_rd ? EXEC : DATA;
      DATA:    if (rx_valid && cnt == 2'd3) state_n = EXEC;
      EXEC:    state_n = is_rd ? RD_WAIT : RESP;
      RD_WAIT: state_n = RESP;
      RESP: begin
        tx_start = tx_ready && resp_cnt != 3'd0;
        if (tx_ready && resp_cnt == 3'd0) state_n = CMD;
      end
      default: state_n = CMD;
    endcase
    if (rx_ferr) state_n = CMD;
  end

  assign mem.mem_we = state == EXEC && !is_rd;
  assign mem.mem_re = state == EXEC && is_rd;
  assign busy = state != CMD;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CMD;
      cnt <= '0;
      is_rd <= 1'b0;
      addr_buf <= '0;
      data_buf <= '0;
      resp_buf <= '0;
      resp_cnt <= '0;
      boot_done <= 1'b0;
      mem.mem_addr <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (rx_valid)
        case (state)
          CMD: begin
            is_rd <= rx_byte == 8'h02;
            cnt <= 2'd0;
            if (rx_byte == 8'h03) boot_done <= 1'b1;
            resp_buf <= {rx_byte == 8'h03 ? ACK : NAK, 24'd0};
            resp_cnt <= 3'd1;
          end
          ADDR: begin
            addr_buf <= {addr_buf[7:0], rx_byte};
            cnt <= cnt[0] ? 2'd0 : cnt + 2'd1;
            if (cnt[0] && is_rd) mem.mem_addr <= {addr_buf[7:0], rx_byte};
          end
          DATA: begin
            data_buf <= {data_buf[15:0], rx_byte};
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              mem.mem_addr <= addr_buf;
              mem.mem_wdata <= {data_buf, rx_byte};
            end
          end
          default: ;
        endcase
      if (state == EXEC && !is_rd) begin
        resp_buf <= {ACK, 24'd0};
        resp_cnt <= 3'd1;
      end
      if (state == RD_WAIT) begin
        resp_buf <= mem.mem_rdata;
        resp_cnt <= 3'd4;
      end
      if (tx_start) begin
        resp_buf <= {resp_buf[23:0], 8'd0};
        resp_cnt <= resp_cnt - 3'd1;
      end
    end
endmodule
